// File: rtl/onchip_ram_arbiter.sv
// Two-master round-robin arbiter for the single-port onchip RAM, with optional
// ownership lock and a one-deep read tag that routes readdatavalid to the issuing master.
module onchip_ram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int BE_W     = DATA_W / 8,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_read,
    input  logic              m0_write,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,

    input  logic              m1_read,
    input  logic              m1_write,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,

    output logic [DATA_W-1:0] m_readdata,

    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    // state | meaning
    // IDLE  | no owner, round-robin between requesters
    // OWN0  | m0 holds the lock, m0 wins while it requests
    // OWN1  | m1 holds the lock, m1 wins while it requests
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int LCW = $clog2(MAX_LOCK + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_tag_q, rd_tag_d;

    logic req0, req1;
    logic gnt0, gnt1, gnt_any;
    logic owned, owner, force_ho;
    logic gnt_write, gnt_lock;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // A lock that reached MAX_LOCK arbitrates like IDLE; rr already points away from the owner.
    assign force_ho = (state_q != IDLE) && (lock_cnt_q == LOCK_MAX);
    assign owned    = (state_q != IDLE) && !force_ho;
    assign owner    = (state_q == OWN1);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (owned) begin
                if (!owner) begin
                    if (req0)      gnt0 = 1'b1;
                    else if (req1) gnt1 = 1'b1;
                end else begin
                    if (req1)      gnt1 = 1'b1;
                    else if (req0) gnt0 = 1'b1;
                end
            end else if (req0 && req1) begin
                gnt0 = !rr_q;
                gnt1 = rr_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign gnt_write = gnt1 ? m1_write : m0_write;
    assign gnt_lock  = gnt1 ? m1_lock  : m0_lock;

    assign m0_waitrequest = !gnt0;
    assign m1_waitrequest = !gnt1;

    assign ram_chipselect = gnt_any;
    assign ram_write      = gnt_any & gnt_write;
    assign ram_address    = gnt1 ? m1_address    : m0_address;
    assign ram_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    assign ram_clken      = !reset;

    assign m_readdata       = ram_readdata;
    assign m0_readdatavalid = rd_valid_q & !rd_tag_q;
    assign m1_readdatavalid = rd_valid_q &  rd_tag_q;

    always_comb begin
        state_d    = IDLE;
        lock_cnt_d = '0;
        rr_d       = rr_q;
        rd_valid_d = gnt_any & !gnt_write;
        rd_tag_d   = gnt1;
        if (gnt_any) begin
            rr_d = !gnt1;
            if (gnt_lock) begin
                if (owned && (gnt1 == owner)) begin
                    state_d    = state_q;
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end else begin
                    state_d    = gnt1 ? OWN1 : OWN0;
                    lock_cnt_d = LCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            lock_cnt_q <= '0;
            rd_valid_q <= 1'b0;
            rd_tag_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_cnt_q <= lock_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_tag_q   <= rd_tag_d;
        end
    end

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed bench for onchip_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_onchip_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_read, m0_write, m0_lock;
    logic [9:0]  m0_address;
    logic [1:0]  m0_byteenable;
    logic [15:0] m0_writedata;
    logic        m0_waitrequest, m0_readdatavalid;
    logic        m1_read, m1_write, m1_lock;
    logic [9:0]  m1_address;
    logic [1:0]  m1_byteenable;
    logic [15:0] m1_writedata;
    logic        m1_waitrequest, m1_readdatavalid;
    logic [15:0] m_readdata;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [9:0]  ram_address;
    logic [1:0]  ram_byteenable;
    logic [15:0] ram_writedata;
    logic [15:0] ram_readdata;

    int errors = 0;
    int checks = 0;
    int cnt0 = 0;
    int cnt1 = 0;
    logic pv0;

    logic [15:0] mem [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                if (ram_byteenable[0]) mem[ram_address][7:0]  <= ram_writedata[7:0];
                if (ram_byteenable[1]) mem[ram_address][15:8] <= ram_writedata[15:8];
            end
            ram_readdata <= mem[ram_address];
        end
    end

    onchip_ram_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_lock          (m0_lock),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_lock          (m1_lock),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdatavalid (m1_readdatavalid),
        .m_readdata       (m_readdata),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_address      (ram_address),
        .ram_byteenable   (ram_byteenable),
        .ram_writedata    (ram_writedata),
        .ram_clken        (ram_clken),
        .ram_readdata     (ram_readdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_read = 1'b1; m0_write = 1'b0; m0_lock = 1'b0;
        m0_address = '0; m0_byteenable = 2'b11; m0_writedata = '0;
        m1_read = 1'b1; m1_write = 1'b0; m1_lock = 1'b0;
        m1_address = '0; m1_byteenable = 2'b11; m1_writedata = '0;

        #3;
        chk("reset_wait0", m0_waitrequest, 1'b1);
        chk("reset_wait1", m1_waitrequest, 1'b1);
        chk("reset_rdv0", m0_readdatavalid, 1'b0);
        chk("reset_cs", ram_chipselect, 1'b0);
        chk("reset_ramwr", ram_write, 1'b0);
        chk("reset_clken", ram_clken, 1'b0);
        tick(); tick();
        m0_read = 1'b0; m1_read = 1'b0; reset = 1'b0;
        #1;
        chk("idle_cs", ram_chipselect, 1'b0);
        chk("idle_clken", ram_clken, 1'b1);
        chk("idle_wait0", m0_waitrequest, 1'b1);

        // preload word 0x200 for the alternation test
        tick();
        m0_write = 1'b1; m0_address = 10'h200; m0_writedata = 16'h2222;
        #1;
        chk("pre_wait0", m0_waitrequest, 1'b0);

        // test 1: write then read back
        tick();
        m0_address = 10'h3A5; m0_writedata = 16'hBEEF; m0_byteenable = 2'b11;
        #1;
        chk("t1_wr_wait0", m0_waitrequest, 1'b0);
        chk("t1_cs", ram_chipselect, 1'b1);
        chk("t1_ramwr", ram_write, 1'b1);
        chk("t1_addr", ram_address, 10'h3A5);
        chk("t1_wdata", ram_writedata, 16'hBEEF);
        tick();
        m0_write = 1'b0; m0_read = 1'b1;
        #1;
        chk("t1_rd_wait0", m0_waitrequest, 1'b0);
        chk("t1_rd_ramwr", ram_write, 1'b0);
        tick();
        m0_read = 1'b0;
        m1_write = 1'b1; m1_address = 10'h300; m1_writedata = 16'h1111;
        #1;
        chk("t1_rdv0", m0_readdatavalid, 1'b1);
        chk("t1_rdv1", m1_readdatavalid, 1'b0);
        chk("t1_data", m_readdata, 16'hBEEF);
        chk("t1_m1wr_wait1", m1_waitrequest, 1'b0);
        tick();
        m1_write = 1'b0;

        // test 2: both read every cycle -> m0, m1 alternate
        m0_address = 10'h200; m1_address = 10'h300;
        for (int k = 0; k <= 8; k++) begin
            m0_read = (k < 8); m1_read = (k < 8);
            #1;
            if (k < 8) begin
                chk($sformatf("t2_wait0_%0d", k), m0_waitrequest, (k % 2 == 1));
                chk($sformatf("t2_wait1_%0d", k), m1_waitrequest, (k % 2 == 0));
            end
            if (k >= 1) begin
                pv0 = ((k - 1) % 2 == 0);
                chk($sformatf("t2_rdv0_%0d", k), m0_readdatavalid, pv0);
                chk($sformatf("t2_rdv1_%0d", k), m1_readdatavalid, !pv0);
                chk($sformatf("t2_data_%0d", k), m_readdata, pv0 ? 16'h2222 : 16'h1111);
                cnt0 += int'(m0_readdatavalid);
                cnt1 += int'(m1_readdatavalid);
            end else begin
                chk("t2_rdv_first", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
            end
            tick();
        end
        chk("t2_cnt0", cnt0, 4);
        chk("t2_cnt1", cnt1, 4);

        // test 3: byte-lane write
        m0_write = 1'b1; m0_address = 10'h000; m0_writedata = 16'hFFFF; m0_byteenable = 2'b11;
        #1;
        chk("t3_wait0", m0_waitrequest, 1'b0);
        tick();
        m0_writedata = 16'h1234; m0_byteenable = 2'b01;
        #1;
        chk("t3_be", ram_byteenable, 2'b01);
        tick();
        m0_write = 1'b0; m0_read = 1'b1; m0_byteenable = 2'b11;
        tick();
        m0_read = 1'b0;
        #1;
        chk("t3_rdv0", m0_readdatavalid, 1'b1);
        chk("t3_data", m_readdata, 16'hFF34);
        tick();

        // test 4: m1 locks for MAX_LOCK grants, m0 gets one slot, m1 resumes
        m0_address = 10'h200; m1_address = 10'h300;
        for (int c = 0; c <= 12; c++) begin
            m0_read = (c <= 8); m1_read = 1'b1; m1_lock = (c != 12);
            #1;
            chk($sformatf("t4_wait0_%0d", c), m0_waitrequest, (c != 8));
            chk($sformatf("t4_wait1_%0d", c), m1_waitrequest, (c == 8));
            if (c >= 1)
                chk($sformatf("t4_rdv0_%0d", c), m0_readdatavalid, (c == 9));
            tick();
        end
        m0_read = 1'b0; m1_read = 1'b0; m1_lock = 1'b0;
        #1;
        chk("t4_last_rdv1", m1_readdatavalid, 1'b1);

        // test 5: reset while a read is in flight
        tick();
        m0_read = 1'b1; m0_address = 10'h005; m1_read = 1'b1;
        #1;
        chk("t5_wait0", m0_waitrequest, 1'b0);
        chk("t5_wait1", m1_waitrequest, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        chk("t5_rst_rdv0", m0_readdatavalid, 1'b0);
        chk("t5_rst_wait0", m0_waitrequest, 1'b1);
        chk("t5_rst_wait1", m1_waitrequest, 1'b1);
        chk("t5_rst_clken", ram_clken, 1'b0);
        chk("t5_rst_cs", ram_chipselect, 1'b0);
        tick();
        chk("t5_rst_rdv0_b", m0_readdatavalid, 1'b0);
        m0_read = 1'b0; m1_read = 1'b0; reset = 1'b0;
        #1;
        chk("t5_post_wait0", m0_waitrequest, 1'b1);

        // test 6: read+write together is a write; rr then favours m1
        tick();
        m0_read = 1'b1; m0_write = 1'b1; m0_address = 10'h010;
        m0_writedata = 16'hCAFE; m0_byteenable = 2'b11;
        #1;
        chk("t6_wait0", m0_waitrequest, 1'b0);
        chk("t6_ramwr", ram_write, 1'b1);
        tick();
        m0_write = 1'b0; m1_read = 1'b1; m1_address = 10'h010;
        #1;
        chk("t6_no_rdv0", m0_readdatavalid, 1'b0);
        chk("t6_rr_wait1", m1_waitrequest, 1'b0);
        chk("t6_rr_wait0", m0_waitrequest, 1'b1);
        tick();
        m1_read = 1'b0;
        #1;
        chk("t6_rdv1", m1_readdatavalid, 1'b1);
        chk("t6_data1", m_readdata, 16'hCAFE);
        chk("t6_m0_wait0", m0_waitrequest, 1'b0);
        tick();
        m0_read = 1'b0;
        #1;
        chk("t6_rdv0", m0_readdatavalid, 1'b1);
        chk("t6_data0", m_readdata, 16'hCAFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
